slice_theta_unit: RTL and testbench

SLICE_THETA_UNIT -- requirements
Module: slice_theta_unit

---
 rtl/slice_theta_unit.sv | 137 +++++++++++++
 tb/tb_slice_theta_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/slice_theta_unit.sv
// Keccak theta step over a slice-serial state: buffers N_SLICES slices with
// their column parities, then streams out the theta-transformed slices.
module slice_theta_unit #(
    parameter int unsigned N_SLICES = 64,
    parameter int unsigned SLICE_W  = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               inValid,
    input  logic [SLICE_W-1:0] sliceIn,
    output logic               ready,
    output logic               putInput,
    output logic               outReady,
    output logic               outValid,
    output logic [SLICE_W-1:0] sliceOut
);

    localparam int unsigned CNT_W = $clog2(N_SLICES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ANNOUNCE,
        EMIT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               accept_c;
    logic [4:0]         par_in_c;
    logic [4:0]         par_cur_c;
    logic [4:0]         par_prv_c;
    logic [4:0]         d_c;
    logic [SLICE_W-1:0] rd_slice_c;
    logic [SLICE_W-1:0] theta_c;

    logic [SLICE_W-1:0] buf_mem [N_SLICES];
    logic [4:0]         par_mem [N_SLICES];

    // Next-state and slice counter sequencing
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                end
            end
            LOAD: begin
                if (inValid) begin
                    accept_c = 1'b1;
                    cnt_nxt  = cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state_nxt = ANNOUNCE;
                    end
                end
            end
            ANNOUNCE: begin
                state_nxt = EMIT;
                cnt_nxt   = '0;
            end
            EMIT: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Column parity of the incoming slice: XOR over y for each x
    always_comb begin
        par_in_c = '0;
        for (int x = 0; x < 5; x++) begin
            par_in_c[x] = sliceIn[x] ^ sliceIn[5 + x] ^ sliceIn[10 + x]
                        ^ sliceIn[15 + x] ^ sliceIn[20 + x];
        end
    end

    // Theta for the slice that will be presented next cycle (index cnt_nxt)
    always_comb begin
        rd_slice_c = buf_mem[cnt_nxt];
        par_cur_c  = par_mem[cnt_nxt];
        par_prv_c  = par_mem[cnt_nxt - CNT_W'(1)];
        d_c        = '0;
        theta_c    = '0;
        for (int x = 0; x < 5; x++) begin
            d_c[x] = par_cur_c[(x + 4) % 5] ^ par_prv_c[(x + 1) % 5];
        end
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                theta_c[5 * y + x] = rd_slice_c[5 * y + x] ^ d_c[x];
            end
        end
    end

    // Slice and parity storage; fully rewritten by every pass, so no reset
    always_ff @(posedge clk) begin
        if (rst && accept_c) begin
            buf_mem[cnt] <= sliceIn;
            par_mem[cnt] <= par_in_c;
        end
    end

    // State, counter and registered handshake/data outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ready    <= 1'b1;
            putInput <= 1'b0;
            outReady <= 1'b0;
            outValid <= 1'b0;
            sliceOut <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ready    <= (state_nxt == IDLE);
            putInput <= (state_nxt == LOAD);
            outReady <= (state_nxt == ANNOUNCE);
            outValid <= (state_nxt == EMIT);
            sliceOut <= (state_nxt == EMIT) ? theta_c : '0;
        end
    end

endmodule

// File: tb/tb_slice_theta_unit.sv
// Directed bench for slice_theta_unit: fixed vectors with hand-derived results
// plus a column-parity model for a pseudo-random state.
module tb_slice_theta_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        inValid;
    logic [24:0] sliceIn;
    logic        ready;
    logic        putInput;
    logic        outReady;
    logic        outValid;
    logic [24:0] sliceOut;

    int checks;
    int errors;

    logic [24:0] img  [64];
    logic [24:0] expv [64];

    slice_theta_unit #(
        .N_SLICES (64),
        .SLICE_W  (25)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .inValid  (inValid),
        .sliceIn  (sliceIn),
        .ready    (ready),
        .putInput (putInput),
        .outReady (outReady),
        .outValid (outValid),
        .sliceOut (sliceOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_onehot(input string tag);
        chk1(tag, 1'($countones({ready, putInput, outReady, outValid}) == 1), 1'b1);
    endtask

    function automatic logic colp(input logic [24:0] s, input int x);
        return s[x] ^ s[x + 5] ^ s[x + 10] ^ s[x + 15] ^ s[x + 20];
    endfunction

    function automatic logic [24:0] theta_ref(input int z);
        logic [24:0] a;
        logic [24:0] p;
        logic [24:0] r;
        a = img[z];
        p = img[(z + 63) % 64];
        r = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                r[5 * y + x] = a[5 * y + x] ^ colp(a, (x + 4) % 5) ^ colp(p, (x + 1) % 5);
            end
        end
        return r;
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 64; i++) begin
            img[i]  = '0;
            expv[i] = '0;
        end
    endtask

    // One full pass: start, load 64 slices (optionally with bubbles and
    // stray start/inValid pokes), then check announce, 64 outputs and idle.
    task automatic run_pass(input bit gaps, input bit poke);
        start = 1'b1;
        step();
        start = 1'b0;
        chk1("putInput_after_start", putInput, 1'b1);
        for (int i = 0; i < 64; i++) begin
            inValid = 1'b1;
            sliceIn = img[i];
            if (poke && i == 10) start = 1'b1;
            step();
            start = 1'b0;
            if (i != 63) begin
                chk1("load_putInput", putInput, 1'b1);
                chk_onehot("load_onehot");
                if (gaps) begin
                    inValid = 1'b0;
                    sliceIn = 25'($urandom);
                    step();
                    chk1("gap_putInput", putInput, 1'b1);
                    chk1("gap_outReady", outReady, 1'b0);
                end
            end
        end
        inValid = 1'b0;
        sliceIn = '0;
        chk1("announce_outReady", outReady, 1'b1);
        chk1("announce_putInput", putInput, 1'b0);
        chk_onehot("announce_onehot");
        for (int z = 0; z < 64; z++) begin
            if (poke && z == 20) begin
                start   = 1'b1;
                inValid = 1'b1;
                sliceIn = 25'($urandom);
            end
            step();
            start   = 1'b0;
            inValid = 1'b0;
            chk1("emit_outValid", outValid, 1'b1);
            chk1("emit_outReady", outReady, 1'b0);
            chkw($sformatf("sliceOut_z%0d", z), sliceOut, expv[z]);
        end
        step();
        chk1("done_ready", ready, 1'b1);
        chk1("done_outValid", outValid, 1'b0);
        chkw("done_sliceOut_zero", sliceOut, 25'h0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        start   = 1'b0;
        inValid = 1'b0;
        sliceIn = '0;
        step();
        step();
        chk1("reset_ready", ready, 1'b1);
        chk1("reset_putInput", putInput, 1'b0);
        chk1("reset_outReady", outReady, 1'b0);
        chk1("reset_outValid", outValid, 1'b0);
        chkw("reset_sliceOut", sliceOut, 25'h0);
        rst = 1'b1;

        // inValid while idle is ignored
        for (int i = 0; i < 3; i++) begin
            inValid = 1'b1;
            sliceIn = 25'($urandom);
            step();
            chk1("idle_ready", ready, 1'b1);
            chk1("idle_putInput", putInput, 1'b0);
        end
        inValid = 1'b0;

        // all-zero state
        clear_img();
        run_pass(1'b0, 1'b0);

        // single bit in slice 0
        clear_img();
        img[0]  = 25'h0000001;
        expv[0] = 25'h0210843;
        expv[1] = 25'h1084210;
        run_pass(1'b0, 1'b0);

        // single bit in slice 63 exercises the z-1 wrap
        clear_img();
        img[63]  = 25'h0000001;
        expv[0]  = 25'h1084210;
        expv[63] = 25'h0210843;
        run_pass(1'b0, 1'b0);

        // pseudo-random state, contiguous then with bubbles and stray pokes
        for (int i = 0; i < 64; i++) img[i] = 25'($urandom);
        for (int z = 0; z < 64; z++) expv[z] = theta_ref(z);
        run_pass(1'b0, 1'b0);
        run_pass(1'b1, 1'b1);

        // abort after 30 slices, then a clean pass must show no residue
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            inValid = 1'b1;
            sliceIn = 25'($urandom);
            step();
        end
        rst     = 1'b0;
        sliceIn = 25'($urandom);
        step();
        rst     = 1'b1;
        inValid = 1'b0;
        chk1("abort_ready", ready, 1'b1);
        chk1("abort_putInput", putInput, 1'b0);
        chk1("abort_outValid", outValid, 1'b0);
        clear_img();
        img[0]  = 25'h0000001;
        expv[0] = 25'h0210843;
        expv[1] = 25'h1084210;
        run_pass(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
